// File: rtl/memShare_pkg.sv
// Shared definitions for the memory-share one-hot to binary converter.
// Provides the multi-hot policy encodings, a default error-counter width
// and a constant-evaluable ceil(log2) helper for parameter defaults.
package memShare_pkg;

   localparam int unsigned MH_XOR            = 0;
   localparam int unsigned MH_LOWEST         = 1;
   localparam int unsigned ERR_CNT_WIDTH_DEF = 8;

   // ceil(log2(n)); returns 0 for n <= 1
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_share_onehot_lane_enc.sv
// Single-lane combinational one-hot to binary encoder.
// Ports:
//   onehot      - one-hot request code for one shared-group lane
//   bin_c       - binary index (XOR of set indices or lowest set index on multi-hot)
//   zero_hot_c  - no bit set
//   multi_hot_c - two or more bits set
module mem_share_onehot_lane_enc
   import memShare_pkg::*;
#(
   parameter int unsigned ONEHOT_CODE_LEN = 8,
   parameter int unsigned BIN_CODE_LEN    = 3,
   parameter int unsigned MULTIHOT_POLICY = MH_XOR
) (
   input  logic [ONEHOT_CODE_LEN-1:0] onehot,
   output logic [BIN_CODE_LEN-1:0]    bin_c,
   output logic                       zero_hot_c,
   output logic                       multi_hot_c
);

   logic [BIN_CODE_LEN-1:0] xor_acc;
   logic [BIN_CODE_LEN-1:0] low_idx;
   logic                    seen;
   logic                    multi;

   // Single scan gives both policies; for a true one-hot they coincide.
   always_comb begin
      xor_acc = '0;
      low_idx = '0;
      seen    = 1'b0;
      multi   = 1'b0;
      for (int i = 0; i < int'(ONEHOT_CODE_LEN); i++) begin
         if (onehot[i]) begin
            xor_acc = xor_acc ^ BIN_CODE_LEN'(i);
            if (seen) multi = 1'b1;
            else      low_idx = BIN_CODE_LEN'(i);
            seen = 1'b1;
         end
      end
   end

   assign bin_c       = (MULTIHOT_POLICY == MH_LOWEST) ? low_idx : xor_acc;
   assign zero_hot_c  = !seen;
   assign multi_hot_c = multi;

endmodule

// File: rtl/mem_share_onehot2bin_pipe.sv
// Multi-lane, two-stage pipelined one-hot to binary converter with
// valid/ready flow control and a saturating error counter.
// Ports:
//   sys_clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready       - input handshake (in_ready combinational from out_ready)
//   onehot_i                - CHANNEL_NUM packed one-hot lanes
//   out_valid/out_ready     - output handshake
//   bin_o                   - CHANNEL_NUM packed binary indices
//   zero_hot_o, multi_hot_o - per-lane error flags, aligned with bin_o
//   err_cnt_o, err_cnt_clr  - saturating count of erroneous words, synchronous clear
module mem_share_onehot2bin_pipe
   import memShare_pkg::*;
#(
   parameter int unsigned CHANNEL_NUM     = 4,
   parameter int unsigned ONEHOT_CODE_LEN = 8,
   parameter int unsigned BIN_CODE_LEN    = clog2(ONEHOT_CODE_LEN),
   parameter int unsigned MULTIHOT_POLICY = MH_XOR,
   parameter int unsigned ERR_CNT_WIDTH   = ERR_CNT_WIDTH_DEF
) (
   input  logic                                   sys_clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [CHANNEL_NUM*ONEHOT_CODE_LEN-1:0] onehot_i,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [CHANNEL_NUM*BIN_CODE_LEN-1:0]    bin_o,
   output logic [CHANNEL_NUM-1:0]                 zero_hot_o,
   output logic [CHANNEL_NUM-1:0]                 multi_hot_o,
   output logic [ERR_CNT_WIDTH-1:0]               err_cnt_o,
   input  logic                                   err_cnt_clr
);

   localparam int unsigned OH_W  = CHANNEL_NUM * ONEHOT_CODE_LEN;
   localparam int unsigned BIN_W = CHANNEL_NUM * BIN_CODE_LEN;

   logic             s1_valid;
   logic [OH_W-1:0]  s1_data;
   logic             s1_load;
   logic             s2_load;
   logic [BIN_W-1:0] enc_bin;
   logic [CHANNEL_NUM-1:0] enc_zh;
   logic [CHANNEL_NUM-1:0] enc_mh;
   logic             word_err;

   // Stage advance: S2 refills when empty or draining, S1 when empty or S2 takes it.
   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Per-lane encoders between S1 and S2
   for (genvar c = 0; c < int'(CHANNEL_NUM); c++) begin : g_lane
      mem_share_onehot_lane_enc #(
         .ONEHOT_CODE_LEN (ONEHOT_CODE_LEN),
         .BIN_CODE_LEN    (BIN_CODE_LEN),
         .MULTIHOT_POLICY (MULTIHOT_POLICY)
      ) u_enc (
         .onehot      (s1_data[c*ONEHOT_CODE_LEN +: ONEHOT_CODE_LEN]),
         .bin_c       (enc_bin[c*BIN_CODE_LEN +: BIN_CODE_LEN]),
         .zero_hot_c  (enc_zh[c]),
         .multi_hot_c (enc_mh[c])
      );
   end

   assign word_err = |{enc_zh, enc_mh};

   // Pipeline registers and error counter
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_data     <= '0;
         out_valid   <= 1'b0;
         bin_o       <= '0;
         zero_hot_o  <= '0;
         multi_hot_o <= '0;
         err_cnt_o   <= '0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) s1_data <= onehot_i;
         end
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               bin_o       <= enc_bin;
               zero_hot_o  <= enc_zh;
               multi_hot_o <= enc_mh;
            end
         end
         // Clear wins over a same-cycle increment; saturate at all-ones.
         if (err_cnt_clr) begin
            err_cnt_o <= '0;
         end else if (s2_load && s1_valid && word_err && !(&err_cnt_o)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
         end
      end
   end

endmodule
